fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls the instruction-fetch stage: owns the program counter and decides each cycle whether it increments, takes a branch, stalls or halts.
- Drives the PC address into InstROM (zero-extended to 9 bits) and a fetch-valid strobe to the decoder.
- Reports halt/done status and a saturating executed-instruction count to the testbench/top level.
- Replaces the free-running "PC+1" loop with a proper run/stall/halt sequencer.

Parameters:
PC_W, 8, program counter width
ADDR_W, 9, InstROM address width; PC is zero-extended into it
START_ADDR, 0, PC value loaded on reset and on start
CNT_W, 16, width of the executed-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin execution from START_ADDR (sampled high for one cycle)
stall  input  1  datapath busy; hold PC this cycle
branch_taken  input  1  decoder: current instruction redirects flow
branch_target  input  PC_W  absolute branch destination
halt_req  input  1  decoder: current instruction is HALT
pc  output  PC_W  current program counter
inst_addr  output  ADDR_W  {0, pc} to InstROM
fetch_valid  output  1  pc/inst_addr hold a live instruction this cycle
done  output  1  sequencer in HALTED
overflow  output  1  halted due to sequential PC wrap past 2^PC_W-1
instr_count  output  CNT_W  instructions retired, saturating

Behaviour:
- Reset (reset low, async): state=IDLE, pc=START_ADDR, fetch_valid=0, done=0, overflow=0, instr_count=0. All outputs take reset values immediately on assertion. Reset mid-run discards everything.
- States: IDLE, RUN, HALTED.
- IDLE:
  - start=1 -> RUN next edge, pc=START_ADDR.
  - Other inputs ignored.
- RUN:
  - fetch_valid=1 combinationally.
  - One instruction retires per non-stalled cycle, with priority halt_req > stall > branch_taken > increment.
  - halt_req=1: pc holds, instr_count+1 (HALT counts as retired), -> HALTED. This applies even if stall=1.
  - stall=1 (no halt_req): pc holds, counter holds, branch_taken ignored. The decoder must hold the branch until stall drops.
  - branch_taken=1: pc<=branch_target, count+1. A branch to the current pc is legal (spin loop).
  - Otherwise pc<=pc+1, count+1.
  - Wrap: sequential increment from 2^PC_W-1 does not wrap. pc holds, count+1, overflow<=1, -> HALTED.
  - A branch from 2^PC_W-1 is legal and does not set overflow.
- HALTED:
  - done=1, fetch_valid=0, pc frozen.
  - start=1 -> RUN, pc=START_ADDR, done=0, overflow=0, instr_count=0.
- start while in RUN is ignored.
- instr_count saturates at 2^CNT_W-1 and does not wrap.
- inst_addr = {(ADDR_W-PC_W){0}, pc}; purely combinational, no added latency.
- Latency: a redirect or increment is visible on pc one clk after the sampling edge.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, RUN, HALTED}
  - PC_W/ADDR_W defaults
  - PC_MAX constant
- One sub-module: sat_counter (CNT_W, enable, clear, async active-low reset), used for instr_count.

Test Plan:
1. reset low 2 cycles, release, start pulse, no branch/stall/halt for 5 cycles -> pc 0,1,2,3,4,5; fetch_valid=1; instr_count=5; inst_addr=9'h005.
2. At pc=3 assert branch_taken, target=8'h40 -> next pc=0x40, then 0x41. Same cycle with stall=1 -> pc stays 3, count unchanged; branch accepted the cycle stall drops.
3. At pc=7 assert halt_req together with branch_taken and stall -> HALTED, pc=7, done=1, fetch_valid=0, count incremented by 1. Later start -> pc=0, done=0, count=0.
4. branch to 0xFE, run freely -> pc 0xFE, 0xFF, then HALTED with overflow=1, pc=0xFF. Repeat with branch at 0xFF to 0x10 -> no overflow, pc=0x10.
5. Drop reset mid-run at pc=0x22 -> outputs reset asynchronously before the next edge; start ignored while reset low; pc=0 afterwards.
6. CNT_W=4 instance, run 20 instructions -> instr_count saturates at 15.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction-fetch sequencer.
//   fetch_state_e : sequencer state encoding (IDLE, RUN, HALTED)
//   PC_W_DEF      : default program counter width
//   ADDR_W_DEF    : default InstROM address width
//   PC_MAX        : last PC value for the default width; stepping past it halts
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam int PC_W_DEF   = 8;
    localparam int ADDR_W_DEF = 9;

    localparam logic [PC_W_DEF-1:0] PC_MAX = '1;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   clr_i : synchronous clear, wins over en_i
//   en_i  : count one event this cycle
//   cnt_o : current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1'b1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter of the fetch stage and decides
// each cycle whether it increments, branches, stalls or halts.
//   clk           : system clock, rising edge
//   reset         : asynchronous active-low reset
//   start         : begin execution from START_ADDR (ignored while running)
//   stall         : datapath busy, hold PC and count
//   branch_taken  : redirect to branch_target
//   branch_target : absolute branch destination
//   halt_req      : current instruction is HALT
//   pc            : current program counter
//   inst_addr     : pc zero-extended for InstROM
//   fetch_valid   : pc holds a live instruction (state RUN)
//   done          : sequencer halted
//   overflow      : halted because sequential fetch ran off the top of PC space
//   instr_count   : retired instructions, saturating
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// RUN    | fetching, one instruction retires per non-stalled cycle
// HALTED | stopped by HALT or PC overflow, waiting for start
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                 PC_W       = PC_W_DEF,
    parameter int                 ADDR_W     = ADDR_W_DEF,
    parameter logic [PC_W-1:0]    START_ADDR = '0,
    parameter int                 CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_target,
    input  logic              halt_req,
    output logic [PC_W-1:0]   pc,
    output logic [ADDR_W-1:0] inst_addr,
    output logic              fetch_valid,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic [PC_W-1:0] PC_LAST = {PC_W{1'b1}};

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            ovf_q, ovf_d;
    logic            cnt_en, cnt_clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ovf_d   = ovf_q;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
                    cnt_clr = 1'b1;
                end
            end
            RUN: begin
                // HALT retires even when the datapath is stalled.
                if (halt_req) begin
                    cnt_en  = 1'b1;
                    state_d = HALTED;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (branch_taken) begin
                    pc_d   = branch_target;
                    cnt_en = 1'b1;
                end else if (pc_q == PC_LAST) begin
                    // Falling off the end of PC space retires the last
                    // instruction and stops rather than wrapping to zero.
                    cnt_en  = 1'b1;
                    ovf_d   = 1'b1;
                    state_d = HALTED;
                end else begin
                    pc_d   = pc_q + PC_W'(1'b1);
                    cnt_en = 1'b1;
                end
            end
            HALTED: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
                    ovf_d   = 1'b0;
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_instr_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (instr_count)
    );

    assign pc          = pc_q;
    assign inst_addr   = {{(ADDR_W-PC_W){1'b0}}, pc_q};
    assign fetch_valid = (state_q == RUN);
    assign done        = (state_q == HALTED);
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stall, branch_taken, halt_req;
    logic [7:0] branch_target;

    logic [7:0]  pc_a, pc_b;
    logic [8:0]  ia_a, ia_b;
    logic        fv_a, fv_b, done_a, done_b, ovf_a, ovf_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;

    fetch_sequencer #(.CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .halt_req(halt_req), .pc(pc_a), .inst_addr(ia_a),
        .fetch_valid(fv_a), .done(done_a), .overflow(ovf_a),
        .instr_count(cnt_a)
    );

    fetch_sequencer #(.CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .halt_req(halt_req), .pc(pc_b), .inst_addr(ia_b),
        .fetch_valid(fv_b), .done(done_b), .overflow(ovf_b),
        .instr_count(cnt_b)
    );

    typedef struct {
        int pc;
        bit fv;
        bit done;
        bit ovf;
        int c16;
        int c4;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: running/halted flags, integer PC and unbounded count.
    bit m_run, m_halted, m_ovf;
    int m_pc, m_cnt;

    function automatic int sat(int v, int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic apply(bit st, bit sl, bit br, bit hl, int tgt);
        exp_t e;
        start         = st;
        stall         = sl;
        branch_taken  = br;
        halt_req      = hl;
        branch_target = tgt[7:0];
        if (!reset) begin
            m_run = 0; m_halted = 0; m_pc = 0; m_cnt = 0; m_ovf = 0;
        end else if (m_run) begin
            if (hl) begin
                m_cnt++; m_run = 0; m_halted = 1;
            end else if (sl) begin
                m_cnt = m_cnt;
            end else if (br) begin
                m_pc = tgt; m_cnt++;
            end else if (m_pc + 1 > 255) begin
                m_cnt++; m_ovf = 1; m_run = 0; m_halted = 1;
            end else begin
                m_pc++; m_cnt++;
            end
        end else if (st) begin
            m_run = 1; m_halted = 0; m_pc = 0; m_ovf = 0; m_cnt = 0;
        end
        e.pc   = m_pc;
        e.fv   = m_run;
        e.done = m_halted;
        e.ovf  = m_ovf;
        e.c16  = sat(m_cnt, 16);
        e.c4   = sat(m_cnt, 4);
        q.push_back(e);
    endtask

    task automatic cycle(bit rs, bit st, bit sl, bit br, bit hl, int tgt);
        @(negedge clk);
        reset = rs;
        apply(st, sl, br, hl, tgt);
    endtask

    task automatic check_reset_now(string name);
        tests++;
        if (pc_a !== 8'd0 || pc_b !== 8'd0 || ia_a !== 9'd0 || fv_a !== 1'b0 ||
            fv_b !== 1'b0 || done_a !== 1'b0 || ovf_a !== 1'b0 ||
            cnt_a !== 16'd0 || cnt_b !== 4'd0) begin
            fails++;
            $display("FAIL %s: got pc=%0h fv=%0b done=%0b ovf=%0b cnt=%0d/%0d, expected all zero",
                     name, pc_a, fv_a, done_a, ovf_a, cnt_a, cnt_b);
        end
    endtask

    // Monitor: one expectation per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (pc_a !== e.pc[7:0] || pc_b !== e.pc[7:0] ||
                    ia_a !== {1'b0, e.pc[7:0]} || ia_b !== {1'b0, e.pc[7:0]} ||
                    fv_a !== e.fv || fv_b !== e.fv ||
                    done_a !== e.done || done_b !== e.done ||
                    ovf_a !== e.ovf || ovf_b !== e.ovf ||
                    cnt_a !== e.c16[15:0] || cnt_b !== e.c4[3:0]) begin
                    fails++;
                    $display("FAIL seq t=%0t: got pc=%0h ia=%0h fv=%0b done=%0b ovf=%0b cnt16=%0d cnt4=%0d, expected pc=%0h fv=%0b done=%0b ovf=%0b cnt16=%0d cnt4=%0d",
                             $time, pc_a, ia_a, fv_a, done_a, ovf_a, cnt_a, cnt_b,
                             e.pc, e.fv, e.done, e.ovf, e.c16, e.c4);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; start = 0; stall = 0; branch_taken = 0; halt_req = 0;
        branch_target = 8'h00;
        m_run = 0; m_halted = 0; m_pc = 0; m_cnt = 0; m_ovf = 0;
        #1;
        check_reset_now("reset_state");

        // 1: reset, start, straight-line run
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        repeat (5) cycle(1, 0, 0, 0, 0, 0);

        // 2: branch held off by stall, then accepted
        cycle(1, 0, 0, 1, 0, 3);
        cycle(1, 0, 1, 1, 0, 8'h40);
        cycle(1, 0, 0, 1, 0, 8'h40);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 8'h41);

        // 3: halt beats stall and branch; restart clears
        cycle(1, 0, 0, 1, 0, 7);
        cycle(1, 0, 1, 1, 1, 8'h55);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);

        // 4: sequential wrap halts with overflow; branch from the top does not
        cycle(1, 0, 0, 1, 0, 8'hFE);
        repeat (3) cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 8'hFF);
        cycle(1, 0, 0, 1, 0, 8'h10);
        cycle(1, 0, 0, 0, 0, 0);

        // 5: asynchronous reset mid-run
        cycle(1, 0, 0, 1, 0, 8'h22);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_now("async_reset");
        apply(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);

        // 6: 4-bit counter saturates at 15
        cycle(1, 1, 0, 0, 0, 0);
        repeat (20) cycle(1, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit rs, st, sl, br, hl;
            int tgt;
            rs  = ($urandom_range(0, 99) != 0);
            st  = ($urandom_range(0, 9) == 0);
            sl  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 4) == 0);
            hl  = ($urandom_range(0, 39) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 255);
            cycle(rs, st, sl, br, hl, tgt);
        end
        cycle(1, 0, 0, 0, 0, 0);

        @(posedge clk);
        #2;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
